// File: rtl/mandel_scan_ctrl.sv
// Frame scan controller for the Mandelbrot engine: raster-walks the pixel grid, accumulates
// complex coordinates, issues one job at a time to the iteration core and forwards tagged results.
`timescale 1ns/1ps
module mandel_scan_ctrl #(
   parameter int DATA_W = 32,
   parameter int DIM_W  = 10,
   parameter int ITER_W = 8
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              cfg_valid,
   input  logic [DATA_W-1:0] cfg_origin_re,
   input  logic [DATA_W-1:0] cfg_origin_im,
   input  logic [DATA_W-1:0] cfg_step,
   input  logic [DIM_W-1:0]  cfg_width,
   input  logic [DIM_W-1:0]  cfg_height,
   input  logic              start,
   input  logic              abort,
   output logic              core_start,
   output logic [DATA_W-1:0] core_c_re,
   output logic [DATA_W-1:0] core_c_im,
   input  logic              core_done,
   input  logic [ITER_W-1:0] core_iters,
   input  logic              core_in_set,
   output logic              pix_valid,
   input  logic              pix_ready,
   output logic [DIM_W-1:0]  pix_x,
   output logic [DIM_W-1:0]  pix_y,
   output logic [ITER_W-1:0] pix_iters,
   output logic              pix_in_set,
   output logic              pix_last,
   output logic              busy,
   output logic              frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_EMIT,
      S_DONE
   } state_t;

   localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

   state_t state_reg, state_next;

   logic [DATA_W-1:0] origin_re_reg, origin_re_next;
   logic [DATA_W-1:0] origin_im_reg, origin_im_next;
   logic [DATA_W-1:0] step_reg, step_next;
   logic [DIM_W-1:0]  width_reg, width_next;
   logic [DIM_W-1:0]  height_reg, height_next;

   logic [DIM_W-1:0]  x_reg, x_next;
   logic [DIM_W-1:0]  y_reg, y_next;
   logic [DATA_W-1:0] c_re_reg, c_re_next;
   logic [DATA_W-1:0] c_im_reg, c_im_next;

   logic [DIM_W-1:0]  pix_x_reg, pix_x_next;
   logic [DIM_W-1:0]  pix_y_reg, pix_y_next;
   logic [ITER_W-1:0] pix_iters_reg, pix_iters_next;
   logic              pix_in_set_reg, pix_in_set_next;
   logic              pix_last_reg, pix_last_next;

   // Config as seen by a start in the same cycle as cfg_valid
   logic [DATA_W-1:0] eff_origin_re;
   logic [DATA_W-1:0] eff_origin_im;
   logic [DIM_W-1:0]  eff_width;
   logic [DIM_W-1:0]  eff_height;
   logic              at_row_end;

   always_comb begin
      eff_origin_re  = cfg_valid ? cfg_origin_re : origin_re_reg;
      eff_origin_im  = cfg_valid ? cfg_origin_im : origin_im_reg;
      eff_width      = cfg_valid ? cfg_width     : width_reg;
      eff_height     = cfg_valid ? cfg_height    : height_reg;
      at_row_end     = (x_reg == width_reg - DIM_ONE);

      state_next      = state_reg;
      origin_re_next  = origin_re_reg;
      origin_im_next  = origin_im_reg;
      step_next       = step_reg;
      width_next      = width_reg;
      height_next     = height_reg;
      x_next          = x_reg;
      y_next          = y_reg;
      c_re_next       = c_re_reg;
      c_im_next       = c_im_reg;
      pix_x_next      = pix_x_reg;
      pix_y_next      = pix_y_reg;
      pix_iters_next  = pix_iters_reg;
      pix_in_set_next = pix_in_set_reg;
      pix_last_next   = pix_last_reg;

      case (state_reg)
         S_IDLE: begin
            if (cfg_valid) begin
               origin_re_next = cfg_origin_re;
               origin_im_next = cfg_origin_im;
               step_next      = cfg_step;
               width_next     = cfg_width;
               height_next    = cfg_height;
            end
            if (start) begin
               if (eff_width == '0 || eff_height == '0) begin
                  state_next = S_DONE;
               end else begin
                  x_next     = '0;
                  y_next     = '0;
                  c_re_next  = eff_origin_re;
                  c_im_next  = eff_origin_im;
                  state_next = S_ISSUE;
               end
            end
         end
         S_ISSUE: state_next = S_WAIT;
         S_WAIT: begin
            if (core_done) begin
               pix_x_next      = x_reg;
               pix_y_next      = y_reg;
               pix_iters_next  = core_iters;
               pix_in_set_next = core_in_set;
               pix_last_next   = at_row_end && (y_reg == height_reg - DIM_ONE);
               state_next      = S_EMIT;
            end
         end
         S_EMIT: begin
            if (pix_ready) begin
               if (pix_last_reg) begin
                  state_next = S_DONE;
               end else if (at_row_end) begin
                  x_next     = '0;
                  y_next     = y_reg + DIM_ONE;
                  c_re_next  = origin_re_reg;
                  c_im_next  = c_im_reg - step_reg;
                  state_next = S_ISSUE;
               end else begin
                  x_next     = x_reg + DIM_ONE;
                  c_re_next  = c_re_reg + step_reg;
                  state_next = S_ISSUE;
               end
            end
         end
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase

      // Abort wins over everything, including a start sampled in IDLE
      if (abort) begin
         state_next = S_IDLE;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_reg      <= S_IDLE;
         origin_re_reg  <= '0;
         origin_im_reg  <= '0;
         step_reg       <= '0;
         width_reg      <= '0;
         height_reg     <= '0;
         x_reg          <= '0;
         y_reg          <= '0;
         c_re_reg       <= '0;
         c_im_reg       <= '0;
         pix_x_reg      <= '0;
         pix_y_reg      <= '0;
         pix_iters_reg  <= '0;
         pix_in_set_reg <= 1'b0;
         pix_last_reg   <= 1'b0;
      end else begin
         state_reg      <= state_next;
         origin_re_reg  <= origin_re_next;
         origin_im_reg  <= origin_im_next;
         step_reg       <= step_next;
         width_reg      <= width_next;
         height_reg     <= height_next;
         x_reg          <= x_next;
         y_reg          <= y_next;
         c_re_reg       <= c_re_next;
         c_im_reg       <= c_im_next;
         pix_x_reg      <= pix_x_next;
         pix_y_reg      <= pix_y_next;
         pix_iters_reg  <= pix_iters_next;
         pix_in_set_reg <= pix_in_set_next;
         pix_last_reg   <= pix_last_next;
      end
   end

   assign core_start = (state_reg == S_ISSUE);
   assign core_c_re  = c_re_reg;
   assign core_c_im  = c_im_reg;
   assign pix_valid  = (state_reg == S_EMIT);
   assign pix_x      = pix_x_reg;
   assign pix_y      = pix_y_reg;
   assign pix_iters  = pix_iters_reg;
   assign pix_in_set = pix_in_set_reg;
   assign pix_last   = pix_last_reg;
   assign busy       = (state_reg != S_IDLE);
   assign frame_done = (state_reg == S_DONE);

endmodule

// File: tb/tb_mandel_scan_ctrl.sv
// Directed bench for mandel_scan_ctrl: a small core responder and sink monitor feed queues
// that are compared against hand-computed pixel/coordinate tables.
`timescale 1ns/1ps
module tb_mandel_scan_ctrl;

   logic        clk = 1'b0;
   logic        nrst;
   logic        cfg_valid;
   logic [31:0] cfg_origin_re, cfg_origin_im, cfg_step;
   logic [9:0]  cfg_width, cfg_height;
   logic        start, abort;
   logic        core_start;
   logic [31:0] core_c_re, core_c_im;
   logic        core_done;
   logic [7:0]  core_iters;
   logic        core_in_set;
   logic        pix_valid, pix_ready;
   logic [9:0]  pix_x, pix_y;
   logic [7:0]  pix_iters;
   logic        pix_in_set, pix_last, busy, frame_done;

   logic        resp_done = 1'b0;
   logic        inj_done;
   logic        resp_en;
   int          resp_lat;
   int          resp_jobs = 0;

   int          n_checks = 0;
   int          n_errors = 0;
   int          n_starts = 0;
   int          n_fd = 0;

   logic [31:0] re_q[$], im_q[$];
   logic [9:0]  rx_q[$], ry_q[$];
   logic [7:0]  rit_q[$];
   logic        rset_q[$], rlast_q[$];

   assign core_done = resp_done | inj_done;

   always #5 clk = ~clk;

   mandel_scan_ctrl #(.DATA_W(32), .DIM_W(10), .ITER_W(8)) dut (
      .clk(clk), .nrst(nrst),
      .cfg_valid(cfg_valid), .cfg_origin_re(cfg_origin_re), .cfg_origin_im(cfg_origin_im),
      .cfg_step(cfg_step), .cfg_width(cfg_width), .cfg_height(cfg_height),
      .start(start), .abort(abort),
      .core_start(core_start), .core_c_re(core_c_re), .core_c_im(core_c_im),
      .core_done(core_done), .core_iters(core_iters), .core_in_set(core_in_set),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
      .pix_iters(pix_iters), .pix_in_set(pix_in_set), .pix_last(pix_last),
      .busy(busy), .frame_done(frame_done)
   );

   // Core model: answers each job resp_lat cycles after core_start, iters = job number
   initial begin
      core_iters  = '0;
      core_in_set = 1'b0;
      forever begin
         @(negedge clk);
         if (core_start && resp_en) begin
            repeat (resp_lat) @(negedge clk);
            core_iters  = resp_jobs[7:0];
            core_in_set = resp_jobs[0];
            resp_done   = 1'b1;
            @(negedge clk);
            resp_done   = 1'b0;
            resp_jobs++;
         end
      end
   end

   // Monitor: issued coordinates, accepted results, frame_done pulses
   always @(negedge clk) begin
      if (core_start) begin
         re_q.push_back(core_c_re);
         im_q.push_back(core_c_im);
         n_starts++;
      end
      if (pix_valid && pix_ready) begin
         rx_q.push_back(pix_x);
         ry_q.push_back(pix_y);
         rit_q.push_back(pix_iters);
         rset_q.push_back(pix_in_set);
         rlast_q.push_back(pix_last);
      end
      if (frame_done) n_fd++;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_cfg(input logic [31:0] re, input logic [31:0] im, input logic [31:0] st,
                           input logic [9:0] w, input logic [9:0] h, input logic with_start);
      cfg_origin_re = re;
      cfg_origin_im = im;
      cfg_step      = st;
      cfg_width     = w;
      cfg_height    = h;
      cfg_valid     = 1'b1;
      start         = with_start;
      tick();
      cfg_valid     = 1'b0;
      start         = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_idle(input int max, input string tag);
      int n = 0;
      while (busy && n < max) begin
         tick();
         n++;
      end
      check(tag, 64'(busy), 64'd0);
   endtask

   task automatic wait_valid(input int max, input string tag);
      int n = 0;
      while (!pix_valid && n < max) begin
         tick();
         n++;
      end
      check(tag, 64'(pix_valid), 64'd1);
   endtask

   // Compares one frame of results against a row-major grid with the given coordinate table
   task automatic check_frame(input int rb, input int cb, input int jb, input int w, input int h,
                              input logic [31:0] exp_re[6], input logic [31:0] exp_im[6]);
      int n = w * h;
      check("frame_count", 64'(rx_q.size() - rb), 64'(n));
      if (rx_q.size() - rb == n && re_q.size() - cb >= n) begin
         for (int i = 0; i < n; i++) begin
            check($sformatf("px%0d", i),    64'(rx_q[rb+i]),   64'(i % w));
            check($sformatf("py%0d", i),    64'(ry_q[rb+i]),   64'(i / w));
            check($sformatf("iters%0d", i), 64'(rit_q[rb+i]),  64'(8'(jb + i)));
            check($sformatf("inset%0d", i), 64'(rset_q[rb+i]), 64'((jb + i) % 2));
            check($sformatf("last%0d", i),  64'(rlast_q[rb+i]), 64'(i == n - 1));
            check($sformatf("cre%0d", i),   64'(re_q[cb+i]),   64'(exp_re[i]));
            check($sformatf("cim%0d", i),   64'(im_q[cb+i]),   64'(exp_im[i]));
         end
      end
   endtask

   localparam logic [31:0] M2_0 = 32'hE000_0000;
   localparam logic [31:0] M1_5 = 32'hE800_0000;
   localparam logic [31:0] M1_0 = 32'hF000_0000;
   localparam logic [31:0] P1_0 = 32'h1000_0000;
   localparam logic [31:0] P0_5 = 32'h0800_0000;

   logic [31:0] grid_re[6];
   logic [31:0] grid_im[6];

   initial begin
      int rb, cb, jb, fd0, ns0;
      logic [9:0] sx;
      logic [7:0] sit;

      grid_re = '{M2_0, M1_5, M1_0, M2_0, M1_5, M1_0};
      grid_im = '{P1_0, P1_0, P1_0, P0_5, P0_5, P0_5};

      nrst = 1'b0; cfg_valid = 1'b0; start = 1'b0; abort = 1'b0; pix_ready = 1'b1;
      cfg_origin_re = '0; cfg_origin_im = '0; cfg_step = '0; cfg_width = '0; cfg_height = '0;
      inj_done = 1'b0; resp_en = 1'b0; resp_lat = 2;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_pix_valid", 64'(pix_valid), 64'd0);
      check("rst_core_start", 64'(core_start), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      repeat (3) @(posedge clk);
      #1 nrst = 1'b1;
      tick();

      // Reset arriving while waiting on the core
      load_cfg(M2_0, P1_0, P0_5, 10'd3, 10'd2, 1'b1);
      repeat (3) tick();
      check("t1_busy_before", 64'(busy), 64'd1);
      #2 nrst = 1'b0;
      #1;
      check("t1_busy", 64'(busy), 64'd0);
      check("t1_core_c_re", 64'(core_c_re), 64'd0);
      check("t1_core_c_im", 64'(core_c_im), 64'd0);
      check("t1_outs", 64'({core_start, pix_valid, pix_last, pix_in_set, frame_done}), 64'd0);
      check("t1_pix_xy", 64'({pix_x, pix_y, pix_iters}), 64'd0);
      tick();
      nrst = 1'b1;
      tick();

      // Full 3x2 frame, core answers after 2 cycles, sink always ready
      resp_en = 1'b1; resp_lat = 2;
      rb = rx_q.size(); cb = re_q.size(); jb = resp_jobs; fd0 = n_fd;
      load_cfg(M2_0, P1_0, P0_5, 10'd3, 10'd2, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("t2_first_core_start", 64'(core_start), 64'd1);
      check("t2_first_c_re", 64'(core_c_re), 64'(M2_0));
      tick();
      check("t2_start_one_cycle", 64'(core_start), 64'd0);
      wait_idle(200, "t2_timeout");
      check_frame(rb, cb, jb, 3, 2, grid_re, grid_im);
      check("t2_frame_done", 64'(n_fd - fd0), 64'd1);

      // Sink stall in EMIT
      rb = rx_q.size(); cb = re_q.size(); jb = resp_jobs;
      resp_lat = 1; pix_ready = 1'b0;
      load_cfg(32'h0, 32'h0, 32'h0000_1000, 10'd2, 10'd1, 1'b1);
      wait_valid(50, "t3_valid_timeout");
      sx = pix_x; sit = pix_iters; ns0 = n_starts;
      repeat (5) tick();
      check("t3_valid_held", 64'(pix_valid), 64'd1);
      check("t3_x_held", 64'(pix_x), 64'(sx));
      check("t3_iters_held", 64'(pix_iters), 64'(sit));
      check("t3_no_issue", 64'(n_starts - ns0), 64'd0);
      pix_ready = 1'b1;
      wait_idle(100, "t3_timeout");
      check("t3_count", 64'(rx_q.size() - rb), 64'd2);
      check("t3_second_issue", 64'(n_starts - ns0), 64'd1);

      // Zero-width frame: no jobs, frame_done straight away
      ns0 = n_starts; fd0 = n_fd;
      load_cfg(32'h0, 32'h0, 32'h1, 10'd0, 10'd4, 1'b1);
      check("t4_frame_done", 64'(frame_done), 64'd1);
      check("t4_busy", 64'(busy), 64'd1);
      tick();
      check("t4_busy_after", 64'(busy), 64'd0);
      check("t4_frame_done_pulse", 64'(frame_done), 64'd0);
      check("t4_no_jobs", 64'(n_starts - ns0), 64'd0);
      check("t4_fd_count", 64'(n_fd - fd0), 64'd1);

      // Abort while pixel (1,0) waits in EMIT
      resp_lat = 2; pix_ready = 1'b0; fd0 = n_fd;
      load_cfg(M2_0, P1_0, P0_5, 10'd3, 10'd2, 1'b1);
      wait_valid(50, "t5_v0_timeout");
      pix_ready = 1'b1;
      tick();
      pix_ready = 1'b0;
      wait_valid(50, "t5_v1_timeout");
      check("t5_abort_at_x", 64'({pix_x, pix_y}), 64'({10'd1, 10'd0}));
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t5_idle", 64'(busy), 64'd0);
      check("t5_valid_drop", 64'(pix_valid), 64'd0);
      inj_done = 1'b1;
      tick();
      inj_done = 1'b0;
      tick();
      check("t5_late_done_ignored", 64'({busy, pix_valid}), 64'd0);
      check("t5_no_frame_done", 64'(n_fd - fd0), 64'd0);
      rb = rx_q.size(); cb = re_q.size(); jb = resp_jobs;
      pix_ready = 1'b1;
      pulse_start();
      wait_idle(200, "t5_timeout");
      check_frame(rb, cb, jb, 3, 2, grid_re, grid_im);
      check("t5_restart_fd", 64'(n_fd - fd0), 64'd1);

      // Coordinate wrap; cfg/start during a frame are ignored
      resp_lat = 1;
      cb = re_q.size(); rb = rx_q.size();
      load_cfg(32'h7FFF_FFFF, 32'h0, 32'h1, 10'd2, 10'd1, 1'b1);
      cfg_origin_re = 32'h1234_5678; cfg_width = 10'd5; cfg_height = 10'd5;
      cfg_valid = 1'b1; start = 1'b1;
      tick();
      cfg_valid = 1'b0; start = 1'b0;
      wait_idle(100, "t6_timeout");
      repeat (3) tick();
      check("t6_no_restart", 64'(busy), 64'd0);
      check("t6_count", 64'(rx_q.size() - rb), 64'd2);
      if (re_q.size() - cb >= 2) begin
         check("t6_re0", 64'(re_q[cb]), 64'h7FFF_FFFF);
         check("t6_re1_wrap", 64'(re_q[cb+1]), 64'h8000_0000);
      end else begin
         check("t6_issue_count", 64'(re_q.size() - cb), 64'd2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
